// File: rtl/hash_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hash_dispatch_pkg
// Brief    : Shared types, IV and message helper for the hash dispatcher.
// Revision : 1.0
// ============================================================================
package hash_dispatch_pkg;

    // Chaining-value IV, word 0 in the least significant slot.
    localparam logic [7:0][31:0] c_IV = {
        32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
        32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0][31:0]  h;
        logic [15:0][31:0] msg;
        logic [31:0]       bl;
        logic [2:0]        flg;
        logic [31:0]       tgt;
    } job_t;

    typedef struct packed {
        logic [31:0]      nonce;
        logic [7:0][31:0] h;
    } sol_t;

    function automatic logic [15:0][31:0] insert_nonce(
        input logic [15:0][31:0] msg,
        input logic [31:0]       nonce,
        input logic [3:0]        idx
    );
        logic [15:0][31:0] m;
        m      = msg;
        m[idx] = nonce;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hash_dispatch_sol.sv
`default_nettype none
// ============================================================================
// Module   : sol_fifo
// Brief    : Power-of-two synchronous FIFO holding found solutions.
// Revision : 1.0
// ============================================================================
module sol_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     Clk,
    input  logic                     Rst_I,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign o_count = r_count;
    assign o_full  = (r_count == (c_AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    always_ff @(posedge Clk or posedge Rst_I) begin
        if (Rst_I) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/hash_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : hash_dispatch
// Brief    : Issues nonce-patched messages to a fixed-latency hasher and
//            collects results under the target into a solution stream.
// Revision : 1.0
// ============================================================================
module hash_dispatch
    import hash_dispatch_pkg::*;
#(
    parameter int PIPE_LAT    = 72,
    parameter int NONCE_IDX   = 15,
    parameter int SFIFO_DEPTH = 4
) (
    input  logic                Clk,
    input  logic                Rst_I,
    input  logic                Job_Vld_I,
    output logic                Job_Rdy_O,
    input  logic [7:0][31:0]    Job_H_I,
    input  logic [15:0][31:0]   Job_Msg_I,
    input  logic [31:0]         Job_BL_I,
    input  logic [2:0]          Job_Flg_I,
    input  logic [31:0]         Job_Tgt_I,
    input  logic [31:0]         Job_NStart_I,
    input  logic [31:0]         Job_NCnt_I,
    input  logic                Stop_I,
    output logic                Msg_Vld_O,
    output logic [7:0][31:0]    Msg_H_O,
    output logic [15:0][31:0]   Msg_O,
    output logic [31:0]         Msg_BL_O,
    output logic [2:0]          Msg_Flg_O,
    input  logic                Res_Vld_I,
    input  logic [7:0][31:0]    Res_H_I,
    output logic                Sol_Vld_O,
    input  logic                Sol_Rdy_I,
    output logic [31:0]         Sol_Nonce_O,
    output logic [7:0][31:0]    Sol_H_O,
    output logic                Busy_O,
    output logic                Done_O,
    output logic [15:0]         Drop_Cnt_O,
    output logic                Sync_Err_O
);
    localparam logic [3:0] c_NONCE_IDX = 4'(NONCE_IDX);

    state_t             r_state;
    state_t             w_state_nxt;
    job_t               r_job;
    logic [31:0]        r_nonce;
    logic [31:0]        r_rem;
    logic [PIPE_LAT-1:0] r_tag_vld;
    logic [31:0]        r_tag_nonce [PIPE_LAT];
    logic               r_sync_err;
    logic [15:0]        r_drop_cnt;

    logic               w_issue;
    logic               w_tag_vld_out;
    logic [31:0]        w_tag_nonce_out;
    logic               w_hit;
    logic               w_pop;
    logic               w_drop;
    logic               w_sol_full;
    logic               w_sol_empty;
    logic [$clog2(SFIFO_DEPTH):0] w_sol_count;
    logic               w_unused;
    sol_t               w_sol_in;
    sol_t               w_sol_head;

    assign w_tag_vld_out   = r_tag_vld[PIPE_LAT-1];
    assign w_tag_nonce_out = r_tag_nonce[PIPE_LAT-1];

    always_comb begin
        w_state_nxt = r_state;
        Job_Rdy_O   = 1'b0;
        w_issue     = 1'b0;
        Done_O      = 1'b0;
        case (r_state)
            IDLE: begin
                Job_Rdy_O = 1'b1;
                if (Job_Vld_I)
                    w_state_nxt = (Job_NCnt_I == 32'd0) ? DRAIN : RUN;
            end
            RUN: begin
                if (Stop_I) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_issue = 1'b1;
                    if (r_rem == 32'd1) w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Done only once every issued nonce has come back.
                if (r_tag_vld == '0) begin
                    Done_O      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst_I) begin
        if (Rst_I) begin
            r_state <= IDLE;
            r_job   <= '{h: c_IV, msg: '0, bl: '0, flg: '0, tgt: '0};
            r_nonce <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (Job_Vld_I && Job_Rdy_O) begin
                r_job   <= '{h: Job_H_I, msg: Job_Msg_I, bl: Job_BL_I,
                             flg: Job_Flg_I, tgt: Job_Tgt_I};
                r_nonce <= Job_NStart_I;
                r_rem   <= Job_NCnt_I;
            end else if (w_issue) begin
                r_nonce <= r_nonce + 32'd1;
                r_rem   <= r_rem - 32'd1;
            end
        end
    end

    assign Msg_Vld_O = w_issue;
    assign Msg_H_O   = r_job.h;
    assign Msg_O     = insert_nonce(r_job.msg, r_nonce, c_NONCE_IDX);
    assign Msg_BL_O  = r_job.bl;
    assign Msg_Flg_O = r_job.flg;
    assign Busy_O    = (r_state != IDLE);

    generate
        if (PIPE_LAT == 1) begin : g_tag_one
            always_ff @(posedge Clk or posedge Rst_I) begin
                if (Rst_I) r_tag_vld <= '0;
                else       r_tag_vld <= w_issue;
            end
            always_ff @(posedge Clk) begin
                r_tag_nonce[0] <= r_nonce;
            end
        end else begin : g_tag_shift
            always_ff @(posedge Clk or posedge Rst_I) begin
                if (Rst_I) r_tag_vld <= '0;
                else       r_tag_vld <= {r_tag_vld[PIPE_LAT-2:0], w_issue};
            end
            always_ff @(posedge Clk) begin
                r_tag_nonce[0] <= r_nonce;
                for (int i = 1; i < PIPE_LAT; i++)
                    r_tag_nonce[i] <= r_tag_nonce[i-1];
            end
        end
    endgenerate

    assign w_hit    = Res_Vld_I & w_tag_vld_out & (Res_H_I[0] <= r_job.tgt);
    assign w_pop    = Sol_Vld_O & Sol_Rdy_I;
    assign w_drop   = w_hit & w_sol_full & ~w_pop;
    assign w_sol_in = '{nonce: w_tag_nonce_out, h: Res_H_I};

    always_ff @(posedge Clk or posedge Rst_I) begin
        if (Rst_I) begin
            r_sync_err <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (Res_Vld_I != w_tag_vld_out) r_sync_err <= 1'b1;
            if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    sol_fifo #(
        .DEPTH (SFIFO_DEPTH),
        .WIDTH ($bits(sol_t))
    ) u_sol_fifo (
        .Clk     (Clk),
        .Rst_I   (Rst_I),
        .i_push  (w_hit),
        .i_data  (w_sol_in),
        .i_pop   (w_pop),
        .o_data  (w_sol_head),
        .o_count (w_sol_count),
        .o_full  (w_sol_full),
        .o_empty (w_sol_empty)
    );

    assign w_unused    = ^w_sol_count;
    assign Sol_Vld_O   = ~w_sol_empty;
    assign Sol_Nonce_O = w_sol_head.nonce;
    assign Sol_H_O     = w_sol_head.h;
    assign Drop_Cnt_O  = r_drop_cnt;
    assign Sync_Err_O  = r_sync_err;

endmodule
`default_nettype wire

// File: tb/tb_hash_dispatch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hash_dispatch
// Brief    : Directed self-checking bench with an ideal fixed-latency hasher.
// Revision : 1.0
// ============================================================================
module tb_hash_dispatch;
    localparam int c_LAT   = 72;
    localparam int c_NIDX  = 15;
    localparam int c_DEPTH = 4;

    logic                Clk = 1'b0;
    logic                Rst_I;
    logic                Job_Vld_I;
    logic                Job_Rdy_O;
    logic [7:0][31:0]    Job_H_I;
    logic [15:0][31:0]   Job_Msg_I;
    logic [31:0]         Job_BL_I;
    logic [2:0]          Job_Flg_I;
    logic [31:0]         Job_Tgt_I;
    logic [31:0]         Job_NStart_I;
    logic [31:0]         Job_NCnt_I;
    logic                Stop_I;
    logic                Msg_Vld_O;
    logic [7:0][31:0]    Msg_H_O;
    logic [15:0][31:0]   Msg_O;
    logic [31:0]         Msg_BL_O;
    logic [2:0]          Msg_Flg_O;
    logic                Res_Vld_I;
    logic [7:0][31:0]    Res_H_I;
    logic                Sol_Vld_O;
    logic                Sol_Rdy_I;
    logic [31:0]         Sol_Nonce_O;
    logic [7:0][31:0]    Sol_H_O;
    logic                Busy_O;
    logic                Done_O;
    logic [15:0]         Drop_Cnt_O;
    logic                Sync_Err_O;

    always #5 Clk = ~Clk;

    hash_dispatch #(
        .PIPE_LAT    (c_LAT),
        .NONCE_IDX   (c_NIDX),
        .SFIFO_DEPTH (c_DEPTH)
    ) u_dut (
        .Clk          (Clk),
        .Rst_I        (Rst_I),
        .Job_Vld_I    (Job_Vld_I),
        .Job_Rdy_O    (Job_Rdy_O),
        .Job_H_I      (Job_H_I),
        .Job_Msg_I    (Job_Msg_I),
        .Job_BL_I     (Job_BL_I),
        .Job_Flg_I    (Job_Flg_I),
        .Job_Tgt_I    (Job_Tgt_I),
        .Job_NStart_I (Job_NStart_I),
        .Job_NCnt_I   (Job_NCnt_I),
        .Stop_I       (Stop_I),
        .Msg_Vld_O    (Msg_Vld_O),
        .Msg_H_O      (Msg_H_O),
        .Msg_O        (Msg_O),
        .Msg_BL_O     (Msg_BL_O),
        .Msg_Flg_O    (Msg_Flg_O),
        .Res_Vld_I    (Res_Vld_I),
        .Res_H_I      (Res_H_I),
        .Sol_Vld_O    (Sol_Vld_O),
        .Sol_Rdy_I    (Sol_Rdy_I),
        .Sol_Nonce_O  (Sol_Nonce_O),
        .Sol_H_O      (Sol_H_O),
        .Busy_O       (Busy_O),
        .Done_O       (Done_O),
        .Drop_Cnt_O   (Drop_Cnt_O),
        .Sync_Err_O   (Sync_Err_O)
    );

    // Ideal hasher: returns each issued nonce exactly c_LAT cycles later.
    // Word 0 = nonce ^ 0x80000000 (or 0 in zero_mode), word i = nonce + i.
    logic [32:0]      hq [$];
    logic             m_vld;
    logic [31:0]      m_nonce;
    logic             zero_mode;
    logic             inj_vld;
    logic [7:0][31:0] inj_h;
    logic [7:0][31:0] model_h;

    always @(posedge Clk) begin
        logic [32:0] e;
        if (Rst_I) begin
            hq.delete();
            m_vld   <= 1'b0;
            m_nonce <= '0;
        end else begin
            hq.push_back({Msg_Vld_O, Msg_O[c_NIDX]});
            if (hq.size() >= c_LAT) begin
                e = hq.pop_front();
                m_vld   <= e[32];
                m_nonce <= e[31:0];
            end else begin
                m_vld <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) model_h[i] = m_nonce + 32'(i);
        model_h[0] = zero_mode ? 32'd0 : (m_nonce ^ 32'h8000_0000);
    end

    assign Res_Vld_I = m_vld | inj_vld;
    assign Res_H_I   = inj_vld ? inj_h : model_h;

    // Observation log sampled on the falling edge.
    int          cyc = 0;
    int          done_cnt, done_cyc, last_iss_cyc, first_res_cyc, first_sol_cyc;
    logic [31:0] iss_q [$];
    logic [31:0] sol_n_q [$];
    logic [31:0] sol_h1_q [$];

    always @(negedge Clk) begin
        cyc++;
        if (Msg_Vld_O) begin
            iss_q.push_back(Msg_O[c_NIDX]);
            last_iss_cyc = cyc;
        end
        if (Done_O) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (Res_Vld_I && first_res_cyc < 0) first_res_cyc = cyc;
        if (Sol_Vld_O && first_sol_cyc < 0) first_sol_cyc = cyc;
        if (Sol_Vld_O && Sol_Rdy_I) begin
            sol_n_q.push_back(Sol_Nonce_O);
            sol_h1_q.push_back(Sol_H_O[1]);
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_mon();
        iss_q.delete();
        sol_n_q.delete();
        sol_h1_q.delete();
        done_cnt      = 0;
        done_cyc      = 0;
        last_iss_cyc  = 0;
        first_res_cyc = -1;
        first_sol_cyc = -1;
    endtask

    task automatic send_job(input logic [31:0] ns, input logic [31:0] cnt, input logic [31:0] tgt);
        chk_eq("job_rdy_before", 32'(Job_Rdy_O), 32'd1);
        Job_NStart_I = ns;
        Job_NCnt_I   = cnt;
        Job_Tgt_I    = tgt;
        Job_Vld_I    = 1'b1;
        tick();
        Job_Vld_I    = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (done_cnt > 0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic chk_done_lat(input string tag);
        int d;
        d = done_cyc - last_iss_cyc;
        chk_eq({tag, "_done_lat_in_window"},
               32'((d >= c_LAT - 1 && d <= c_LAT + 1) ? 1 : 0), 32'd1);
    endtask

    initial begin
        Rst_I        = 1'b1;
        Job_Vld_I    = 1'b0;
        Stop_I       = 1'b0;
        Sol_Rdy_I    = 1'b1;
        zero_mode    = 1'b0;
        inj_vld      = 1'b0;
        inj_h        = '0;
        Job_BL_I     = 32'd64;
        Job_Flg_I    = 3'b101;
        Job_Tgt_I    = '0;
        Job_NStart_I = '0;
        Job_NCnt_I   = '0;
        for (int i = 0; i < 8; i++)  Job_H_I[i]   = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < 16; i++) Job_Msg_I[i] = 32'h1000_0000 + 32'(i);
        clear_mon();

        // Reset state
        repeat (3) tick();
        @(negedge Clk);
        chk_eq("rst_busy",     32'(Busy_O),     32'd0);
        chk_eq("rst_msg_vld",  32'(Msg_Vld_O),  32'd0);
        chk_eq("rst_sol_vld",  32'(Sol_Vld_O),  32'd0);
        chk_eq("rst_done",     32'(Done_O),     32'd0);
        chk_eq("rst_drop",     32'(Drop_Cnt_O), 32'd0);
        chk_eq("rst_sync",     32'(Sync_Err_O), 32'd0);
        tick();
        Rst_I = 1'b0;
        tick();
        chk_eq("rst_job_rdy",  32'(Job_Rdy_O),  32'd1);

        // Basic job: nonces 100..104, all hits
        clear_mon();
        send_job(32'd100, 32'd5, 32'hFFFF_FFFF);
        @(negedge Clk);
        chk_eq("t1_first_issue", 32'(Msg_Vld_O), 32'd1);
        chk_eq("t1_msg_w0",      Msg_O[0],       32'h1000_0000);
        chk_eq("t1_msg_h3",      Msg_H_O[3],     32'hA000_0003);
        chk_eq("t1_msg_bl",      Msg_BL_O,       32'd64);
        chk_eq("t1_msg_flg",     32'(Msg_Flg_O), 32'd5);
        chk_eq("t1_busy",        32'(Busy_O),    32'd1);
        chk_eq("t1_rdy_low",     32'(Job_Rdy_O), 32'd0);
        wait_done("t1");
        repeat (3) tick();
        chk_eq("t1_iss_count", 32'(iss_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk_eq($sformatf("t1_iss%0d", i), iss_q[i], 32'd100 + 32'(i));
        chk_eq("t1_sol_count", 32'(sol_n_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk_eq($sformatf("t1_sol%0d", i),   sol_n_q[i],  32'd100 + 32'(i));
            chk_eq($sformatf("t1_solh1_%0d", i), sol_h1_q[i], 32'd101 + 32'(i));
        end
        chk_eq("t1_done_pulses", 32'(done_cnt), 32'd1);
        chk_done_lat("t1");
        chk_eq("t1_sol_after_res", 32'(first_sol_cyc), 32'(first_res_cyc + 1));
        chk_eq("t1_no_sync_err",   32'(Sync_Err_O),    32'd0);
        chk_eq("t1_rdy_after",     32'(Job_Rdy_O),     32'd1);

        // Nonce wrap; target boundary keeps three, rejects one
        clear_mon();
        send_job(32'hFFFF_FFFE, 32'd4, 32'h8000_0000);
        wait_done("t2");
        repeat (3) tick();
        chk_eq("t2_iss_count", 32'(iss_q.size()), 32'd4);
        chk_eq("t2_iss0", iss_q[0], 32'hFFFF_FFFE);
        chk_eq("t2_iss1", iss_q[1], 32'hFFFF_FFFF);
        chk_eq("t2_iss2", iss_q[2], 32'h0000_0000);
        chk_eq("t2_iss3", iss_q[3], 32'h0000_0001);
        chk_eq("t2_sol_count", 32'(sol_n_q.size()), 32'd3);
        chk_eq("t2_sol0", sol_n_q[0], 32'hFFFF_FFFE);
        chk_eq("t2_sol1", sol_n_q[1], 32'hFFFF_FFFF);
        chk_eq("t2_sol2", sol_n_q[2], 32'h0000_0000);

        // Backpressure overflow: six hits into a four-deep FIFO
        clear_mon();
        zero_mode = 1'b1;
        Sol_Rdy_I = 1'b0;
        send_job(32'd200, 32'd6, 32'd0);
        wait_done("t3");
        repeat (3) tick();
        chk_eq("t3_sol_vld",   32'(Sol_Vld_O),  32'd1);
        chk_eq("t3_drop",      32'(Drop_Cnt_O), 32'd2);
        chk_eq("t3_head",      Sol_Nonce_O,     32'd200);
        chk_eq("t3_head_h0",   Sol_H_O[0],      32'd0);
        chk_eq("t3_head_h1",   Sol_H_O[1],      32'd201);
        chk_eq("t3_no_pops",   32'(sol_n_q.size()), 32'd0);
        Sol_Rdy_I = 1'b1;
        repeat (6) tick();
        chk_eq("t3_drained", 32'(sol_n_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk_eq($sformatf("t3_sol%0d", i), sol_n_q[i], 32'd200 + 32'(i));
        chk_eq("t3_empty", 32'(Sol_Vld_O), 32'd0);
        zero_mode = 1'b0;

        // Stop on the third issue cycle
        clear_mon();
        send_job(32'd300, 32'd10, 32'hFFFF_FFFF);
        tick();
        tick();
        Stop_I = 1'b1;
        @(negedge Clk);
        chk_eq("t4_stop_no_issue", 32'(Msg_Vld_O), 32'd0);
        tick();
        tick();
        chk_eq("t4_drain_busy", 32'(Busy_O), 32'd1);
        Stop_I = 1'b0;
        wait_done("t4");
        repeat (3) tick();
        chk_eq("t4_iss_count", 32'(iss_q.size()), 32'd2);
        chk_eq("t4_iss0", iss_q[0], 32'd300);
        chk_eq("t4_iss1", iss_q[1], 32'd301);
        chk_done_lat("t4");
        chk_eq("t4_sol_count", 32'(sol_n_q.size()), 32'd2);
        chk_eq("t4_rdy_after", 32'(Job_Rdy_O), 32'd1);

        // Untagged result: sticky sync error, nothing stored
        clear_mon();
        chk_eq("t5_sync_before", 32'(Sync_Err_O), 32'd0);
        inj_h   = '0;
        inj_vld = 1'b1;
        tick();
        inj_vld = 1'b0;
        @(negedge Clk);
        chk_eq("t5_sync_set", 32'(Sync_Err_O), 32'd1);
        repeat (5) tick();
        chk_eq("t5_sync_sticky", 32'(Sync_Err_O), 32'd1);
        chk_eq("t5_no_sol",      32'(Sol_Vld_O),  32'd0);

        // Reset in the middle of a run
        clear_mon();
        send_job(32'd400, 32'd20, 32'hFFFF_FFFF);
        tick();
        tick();
        Rst_I = 1'b1;
        @(negedge Clk);
        chk_eq("t6_busy",    32'(Busy_O),     32'd0);
        chk_eq("t6_msg_vld", 32'(Msg_Vld_O),  32'd0);
        chk_eq("t6_sol_vld", 32'(Sol_Vld_O),  32'd0);
        chk_eq("t6_done",    32'(Done_O),     32'd0);
        chk_eq("t6_drop",    32'(Drop_Cnt_O), 32'd0);
        chk_eq("t6_sync",    32'(Sync_Err_O), 32'd0);
        tick();
        Rst_I = 1'b0;
        tick();
        chk_eq("t6_rdy", 32'(Job_Rdy_O), 32'd1);
        clear_mon();
        send_job(32'd500, 32'd3, 32'hFFFF_FFFF);
        wait_done("t6");
        repeat (3) tick();
        chk_eq("t6_iss_count", 32'(iss_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) chk_eq($sformatf("t6_iss%0d", i), iss_q[i], 32'd500 + 32'(i));
        chk_eq("t6_sol_count", 32'(sol_n_q.size()), 32'd3);
        chk_eq("t6_sol0", sol_n_q[0], 32'd500);
        chk_eq("t6_done_pulses", 32'(done_cnt), 32'd1);
        chk_eq("t6_sync_after",  32'(Sync_Err_O), 32'd0);

        // Zero-count job: straight to drain, nothing issued
        clear_mon();
        send_job(32'd600, 32'd0, 32'hFFFF_FFFF);
        wait_done("t7");
        repeat (2) tick();
        chk_eq("t7_no_issue", 32'(iss_q.size()), 32'd0);
        chk_eq("t7_done_pulses", 32'(done_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
